// File: rtl/lcd_hd44780_nibble_ctrl.sv
// HD44780 4-bit write-only controller: power-on init, then command/data bytes over valid/ready.
// Every delay is derived from CLK_KHZ; E, RS and DB7..DB4 come straight from registers.
module lcd_hd44780_nibble_ctrl #(
  parameter int unsigned CLK_KHZ      = 50000,
  parameter int unsigned EN_CYC       = 12,
  parameter bit          TWO_LINE     = 1'b1,
  parameter logic [7:0]  ENTRY_MODE   = 8'h06,
  parameter logic [7:0]  DISPLAY_CTRL = 8'h0C
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam logic [31:0] T15000    = 32'(CLK_KHZ * 15000 / 1000);
  localparam logic [31:0] T4100     = 32'(CLK_KHZ * 4100 / 1000);
  localparam logic [31:0] T100      = 32'(CLK_KHZ * 100 / 1000);
  localparam logic [31:0] T40       = 32'(CLK_KHZ * 40 / 1000);
  localparam logic [31:0] T1640     = 32'(CLK_KHZ * 1640 / 1000);
  // A zero-length wait would never terminate, so very slow clocks still get one cycle.
  localparam logic [31:0] GAP       = (CLK_KHZ >= 1000) ? 32'(CLK_KHZ / 1000) : 32'd1;
  localparam logic [31:0] PULSE_LEN = (EN_CYC >= 1) ? 32'(EN_CYC) : 32'd1;
  localparam logic [7:0]  FUNC_SET  = TWO_LINE ? 8'h28 : 8'h20;

  typedef enum logic [2:0] {
    PWR_WAIT, SETUP, PULSE, HOLD, GAP_WAIT, NIB_WAIT, POST_WAIT, IDLE
  } stateType;

  stateType    state;
  logic [31:0] count;
  logic [2:0]  step;
  logic        byteMode;
  logic        lowPhase;
  logic [7:0]  curByte;
  logic        curRs;

  logic [31:0] waitLen;
  logic        waitDone;
  logic        longPost;
  logic [2:0]  nextStep;
  logic [7:0]  nextInitByte;

  function automatic logic [31:0] nibWaitLen(input logic [2:0] s);
    case (s)
      3'd0:    nibWaitLen = T4100;
      3'd1:    nibWaitLen = T100;
      default: nibWaitLen = T40;
    endcase
  endfunction

  function automatic logic [3:0] initNibble(input logic [2:0] s);
    case (s)
      3'd3:    initNibble = 4'h2;
      default: initNibble = 4'h3;
    endcase
  endfunction

  function automatic logic [7:0] initByte(input logic [2:0] s);
    case (s)
      3'd4:    initByte = FUNC_SET;
      3'd5:    initByte = ENTRY_MODE;
      3'd6:    initByte = DISPLAY_CTRL;
      default: initByte = 8'h01;
    endcase
  endfunction

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  // Length of the wait owned by the current state, and next init step to launch.
  always_comb begin
    longPost     = !curRs && (curByte[7:2] == 6'd0);
    nextStep     = step + 3'd1;
    nextInitByte = initByte(nextStep);
    waitLen      = 32'd1;
    case (state)
      PWR_WAIT:  waitLen = T15000;
      PULSE:     waitLen = PULSE_LEN;
      GAP_WAIT:  waitLen = GAP;
      NIB_WAIT:  waitLen = nibWaitLen(step);
      POST_WAIT: waitLen = longPost ? T1640 : T40;
      default:   waitLen = 32'd1;
    endcase
    waitDone = (count == (waitLen - 32'd1));
  end

  // Sequencer: init steps and host bytes share the nibble phases and one counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state               <= PWR_WAIT;
      count               <= 32'd0;
      step                <= 3'd0;
      byteMode            <= 1'b0;
      lowPhase            <= 1'b0;
      curByte             <= 8'h00;
      curRs               <= 1'b0;
      oReady              <= 1'b0;
      oInitDone           <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= 4'h0;
    end else begin
      count <= count + 32'd1;
      case (state)
        PWR_WAIT: begin
          if (waitDone) begin
            state               <= SETUP;
            count               <= 32'd0;
            step                <= 3'd0;
            byteMode            <= 1'b0;
            oLCD_RegisterSelect <= 1'b0;
            oLCD_Data           <= initNibble(3'd0);
          end
        end
        SETUP: begin
          state        <= PULSE;
          count        <= 32'd0;
          oLCD_Enabled <= 1'b1;
        end
        PULSE: begin
          if (waitDone) begin
            state        <= HOLD;
            count        <= 32'd0;
            oLCD_Enabled <= 1'b0;
          end
        end
        HOLD: begin
          count <= 32'd0;
          if (!byteMode) begin
            state <= NIB_WAIT;
          end else if (!lowPhase) begin
            state <= GAP_WAIT;
          end else begin
            state <= POST_WAIT;
          end
        end
        GAP_WAIT: begin
          if (waitDone) begin
            state     <= SETUP;
            count     <= 32'd0;
            lowPhase  <= 1'b1;
            oLCD_Data <= curByte[3:0];
          end
        end
        NIB_WAIT, POST_WAIT: begin
          if (waitDone) begin
            count <= 32'd0;
            // Host bytes, and the last init byte, fall back to IDLE.
            if (oInitDone || (step == 3'd7)) begin
              state     <= IDLE;
              oReady    <= 1'b1;
              oInitDone <= 1'b1;
            end else begin
              state               <= SETUP;
              step                <= nextStep;
              oLCD_RegisterSelect <= 1'b0;
              if (nextStep[2]) begin
                byteMode  <= 1'b1;
                lowPhase  <= 1'b0;
                curByte   <= nextInitByte;
                curRs     <= 1'b0;
                oLCD_Data <= nextInitByte[7:4];
              end else begin
                byteMode  <= 1'b0;
                oLCD_Data <= initNibble(nextStep);
              end
            end
          end
        end
        IDLE: begin
          if (iValid) begin
            state               <= SETUP;
            count               <= 32'd0;
            oReady              <= 1'b0;
            byteMode            <= 1'b1;
            lowPhase            <= 1'b0;
            curByte             <= iData;
            curRs               <= iRS;
            oLCD_RegisterSelect <= iRS;
            oLCD_Data           <= iData[7:4];
          end
        end
        default: begin
          state <= PWR_WAIT;
          count <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_nibble_ctrl.sv
// Bench: two controllers (scaled-down clocks) checked via a pulse monitor on E, RS and DB7..DB4.
module tb_lcd_hd44780_nibble_ctrl;

  typedef struct {
    logic [3:0] nib;
    logic       rs;
    int         width;
    int         lowBefore;
    bit         stable;
  } pulse_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy;
  } vec_t;

  // Instance 0: CLK_KHZ=1000, EN_CYC=3, one line, display ctrl 0F. Instance 1: CLK_KHZ=2000, EN_CYC=12.
  localparam int INIT0 = 21104;
  localparam int INIT1 = 42256;

  logic       Clock = 1'b0;
  logic       resetIn [2];
  logic       validIn [2];
  logic       rsIn    [2];
  logic [7:0] dataIn  [2];
  wire  [1:0] readyS, initS, eS, rsS, rwS, sfS;
  wire  [3:0] dS [2];

  int checks = 0;
  int failures = 0;
  int tReady [2];
  int tInit  [2];
  pulse_t pq0[$];
  pulse_t pq1[$];

  always #5 Clock = ~Clock;

  lcd_hd44780_nibble_ctrl #(
    .CLK_KHZ(1000), .EN_CYC(3), .TWO_LINE(1'b0), .ENTRY_MODE(8'h06), .DISPLAY_CTRL(8'h0F)
  ) dut (
    .Clock(Clock), .Reset(resetIn[0]), .iValid(validIn[0]), .iRS(rsIn[0]), .iData(dataIn[0]),
    .oReady(readyS[0]), .oInitDone(initS[0]), .oLCD_Enabled(eS[0]),
    .oLCD_RegisterSelect(rsS[0]), .oLCD_ReadWrite(rwS[0]),
    .oLCD_StrataFlashControl(sfS[0]), .oLCD_Data(dS[0])
  );

  lcd_hd44780_nibble_ctrl #(
    .CLK_KHZ(2000), .EN_CYC(12), .TWO_LINE(1'b1), .ENTRY_MODE(8'h06), .DISPLAY_CTRL(8'h0C)
  ) dut2 (
    .Clock(Clock), .Reset(resetIn[1]), .iValid(validIn[1]), .iRS(rsIn[1]), .iData(dataIn[1]),
    .oReady(readyS[1]), .oInitDone(initS[1]), .oLCD_Enabled(eS[1]),
    .oLCD_RegisterSelect(rsS[1]), .oLCD_ReadWrite(rwS[1]),
    .oLCD_StrataFlashControl(sfS[1]), .oLCD_Data(dS[1])
  );

  // Pulse monitor: records nibble, RS, high width and preceding low time of every E pulse.
  initial begin
    pulse_t cur [2];
    bit     inP [2];
    int     lowRun [2];
    for (int k = 0; k < 2; k++) begin
      inP[k] = 1'b0;
      lowRun[k] = 0;
    end
    forever begin
      @(negedge Clock);
      for (int k = 0; k < 2; k++) begin
        if (eS[k]) begin
          if (!inP[k]) begin
            inP[k] = 1'b1;
            cur[k].nib = dS[k];
            cur[k].rs = rsS[k];
            cur[k].width = 0;
            cur[k].lowBefore = lowRun[k];
            cur[k].stable = 1'b1;
          end
          cur[k].width++;
          if (dS[k] != cur[k].nib || rsS[k] != cur[k].rs) cur[k].stable = 1'b0;
        end else begin
          if (inP[k]) begin
            inP[k] = 1'b0;
            if (k == 0) pq0.push_back(cur[k]);
            else pq1.push_back(cur[k]);
            lowRun[k] = 0;
          end
          lowRun[k]++;
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkPulse(input int k, input string name, input logic [3:0] nib,
                            input logic rs, input int width, input int low);
    pulse_t p;
    if ((k == 0 && pq0.size() == 0) || (k == 1 && pq1.size() == 0)) begin
      check({name, "_present"}, 0, 1);
      return;
    end
    if (k == 0) p = pq0.pop_front();
    else p = pq1.pop_front();
    check({name, "_nib"}, longint'(p.nib), longint'(nib));
    check({name, "_rs"}, longint'(p.rs), longint'(rs));
    check({name, "_width"}, p.width, width);
    check({name, "_stable"}, longint'(p.stable), 1);
    if (low >= 0) check({name, "_gap"}, p.lowBefore, low);
  endtask

  task automatic checkInit(input int k, input string tag, input logic [47:0] seq, input int en);
    for (int i = 0; i < 12; i++)
      checkPulse(k, $sformatf("%s_n%0d", tag, i), seq[47-4*i -: 4], 1'b0, en, -1);
    check({tag, "_extra"}, (k == 0) ? pq0.size() : pq1.size(), 0);
  endtask

  // Counts posedges from reset release until oReady/oInitDone first show up.
  task automatic runInit(input bit [1:0] want, input bit spam);
    bit done [2];
    for (int k = 0; k < 2; k++) begin
      done[k] = !want[k];
      tReady[k] = -1;
      tInit[k] = -1;
    end
    for (int c = 1; c <= 45000 && !(done[0] && done[1]); c++) begin
      @(posedge Clock);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!done[k] && (readyS[k] || initS[k])) begin
          done[k] = 1'b1;
          tReady[k] = readyS[k] ? c : -1;
          tInit[k] = initS[k] ? c : -1;
        end
      end
      if (spam) begin
        validIn[0] = (c < INIT0 - 14);
        dataIn[0] = 8'(c);
        rsIn[0] = c[0];
      end
    end
    validIn[0] = 1'b0;
  endtask

  task automatic writeByte(input int k, input logic rs, input logic [7:0] d, output int busy);
    busy = 0;
    @(negedge Clock);
    while (!readyS[k] && busy < 5000) begin
      @(negedge Clock);
      busy++;
    end
    validIn[k] = 1'b1;
    rsIn[k] = rs;
    dataIn[k] = d;
    @(negedge Clock);
    validIn[k] = 1'b0;
    dataIn[k] = ~d;
    rsIn[k] = ~rs;
    busy = 0;
    while (!readyS[k] && busy < 100000) begin
      busy++;
      @(negedge Clock);
    end
  endtask

  initial begin
    vec_t vecs [8];
    int busy;
    int cyc;
    int nAcc;
    logic [7:0] v;
    logic [7:0] expQ[$];

    vecs[0] = '{1'b1, 8'h41, 51};
    vecs[1] = '{1'b0, 8'h01, 1651};
    vecs[2] = '{1'b0, 8'h80, 51};
    vecs[3] = '{1'b1, 8'h01, 51};
    vecs[4] = '{1'b0, 8'h02, 1651};
    vecs[5] = '{1'b0, 8'h03, 1651};
    vecs[6] = '{1'b0, 8'h04, 51};
    vecs[7] = '{1'b1, 8'h00, 51};

    for (int k = 0; k < 2; k++) begin
      resetIn[k] = 1'b1;
      validIn[k] = 1'b0;
      rsIn[k] = 1'b0;
      dataIn[k] = 8'h00;
    end
    repeat (3) @(negedge Clock);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d_ready", k), longint'(readyS[k]), 0);
      check($sformatf("rst%0d_initdone", k), longint'(initS[k]), 0);
      check($sformatf("rst%0d_e", k), longint'(eS[k]), 0);
      check($sformatf("rst%0d_rs", k), longint'(rsS[k]), 0);
      check($sformatf("rst%0d_data", k), longint'(dS[k]), 0);
      check($sformatf("rst%0d_rw", k), longint'(rwS[k]), 0);
      check($sformatf("rst%0d_sf", k), longint'(sfS[k]), 1);
    end

    // Power-on init on both instances.
    resetIn[0] = 1'b0;
    resetIn[1] = 1'b0;
    runInit(2'b11, 1'b0);
    check("init0_ready_time", tReady[0], INIT0);
    check("init0_done_time", tInit[0], INIT0);
    check("init1_ready_time", tReady[1], INIT1);
    check("init1_done_time", tInit[1], INIT1);
    checkInit(0, "init0", 48'h333220060F01, 3);
    checkInit(1, "init1", 48'h333228060C01, 12);

    // Full-size pulse widths on the second instance.
    writeByte(1, 1'b1, 8'h41, busy);
    check("d2_data_busy", busy, 110);
    checkPulse(1, "d2_data_hi", 4'h4, 1'b1, 12, -1);
    checkPulse(1, "d2_data_lo", 4'h1, 1'b1, 12, 4);
    writeByte(1, 1'b0, 8'h01, busy);
    check("d2_clear_busy", busy, 3310);
    checkPulse(1, "d2_clear_hi", 4'h0, 1'b0, 12, -1);
    checkPulse(1, "d2_clear_lo", 4'h1, 1'b0, 12, 4);

    // Table of single writes.
    for (int i = 0; i < 8; i++) begin
      writeByte(0, vecs[i].rs, vecs[i].data, busy);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      checkPulse(0, $sformatf("vec%0d_hi", i), vecs[i].data[7:4], vecs[i].rs, 3, -1);
      checkPulse(0, $sformatf("vec%0d_lo", i), vecs[i].data[3:0], vecs[i].rs, 3, 3);
    end

    // Back-to-back: iValid held, data changing every cycle.
    nAcc = 0;
    cyc = 0;
    v = 8'h3C;
    @(negedge Clock);
    rsIn[0] = 1'b1;
    while (nAcc < 3 && cyc < 2000) begin
      v = v + 8'h27;
      dataIn[0] = v;
      validIn[0] = 1'b1;
      if (readyS[0]) begin
        expQ.push_back(v);
        nAcc++;
      end
      @(negedge Clock);
      cyc++;
    end
    validIn[0] = 1'b0;
    check("b2b_accepts", nAcc, 3);
    cyc = 0;
    while (!readyS[0] && cyc < 500) begin
      @(negedge Clock);
      cyc++;
    end
    check("b2b_pulses", pq0.size(), 2 * expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      checkPulse(0, $sformatf("b2b%0d_hi", i), expQ[i][7:4], 1'b1, 3, -1);
      checkPulse(0, $sformatf("b2b%0d_lo", i), expQ[i][3:0], 1'b1, 3, 3);
    end

    // Reset in the middle of an E pulse.
    @(negedge Clock);
    validIn[0] = 1'b1;
    rsIn[0] = 1'b1;
    dataIn[0] = 8'h5A;
    @(negedge Clock);
    validIn[0] = 1'b0;
    cyc = 0;
    while (!eS[0] && cyc < 100) begin
      @(negedge Clock);
      cyc++;
    end
    check("midop_e_high", longint'(eS[0]), 1);
    @(negedge Clock);
    resetIn[0] = 1'b1;
    @(posedge Clock);
    #1;
    check("midop_e", longint'(eS[0]), 0);
    check("midop_rs", longint'(rsS[0]), 0);
    check("midop_data", longint'(dS[0]), 0);
    check("midop_ready", longint'(readyS[0]), 0);
    check("midop_initdone", longint'(initS[0]), 0);
    @(negedge Clock);
    @(negedge Clock);
    pq0.delete();
    resetIn[0] = 1'b0;
    runInit(2'b01, 1'b1);
    check("reinit_ready_time", tReady[0], INIT0);
    check("reinit_done_time", tInit[0], INIT0);
    repeat (5) @(negedge Clock);
    check("reinit_still_ready", longint'(readyS[0]), 1);
    checkInit(0, "reinit", 48'h333220060F01, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
